multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: instruction  in  32  current instruction-register contents.
REQ-004 SHALL have port: mem_ready  in  1  shared memory has completed the current access.
REQ-005 SHALL have port: branch_taken  in  1  ALU compare result, valid in EXEC.
REQ-006 SHALL have outputs, each out 1, registered/decoded from state: PCWrite, PCSrc (1 = branch target from old PC), IRWrite, MemRead, MemWrite, MemToReg, ALUSrc (1 = immediate), RegWrite, Illegal (one-cycle pulse).
REQ-007 SHALL have port: ALUOp  out  2  00 add, 01 branch compare, 10 funct3/funct7 decode.
REQ-008 SHALL have port: state  out  3  current FSM state, for debug.

Function
REQ-009 SHALL classify instruction[14:12],[6:0] as: R (0110011, funct3 000/001/100/101/110/111); I (0010011, funct3 000/001); LOAD (0000011, funct3 010); STORE (0100011, funct3 010); BRANCH (1100011, funct3 000/001/100/101); else ILLEGAL.
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL recover to FETCH next cycle with all outputs 0.
REQ-011 FETCH: MemRead=1, ALUOp=00; hold until mem_ready; on mem_ready assert IRWrite=1 and PCWrite=1 (PCSrc=0) for that cycle, go DECODE.
REQ-012 DECODE: latch class into an internal register; ILLEGAL -> Illegal=1 for one cycle, go FETCH; else go EXEC.
REQ-013 EXEC: R -> ALUSrc=0, ALUOp=10, go WB; I -> ALUSrc=1, ALUOp=10, go WB; LOAD/STORE -> ALUSrc=1, ALUOp=00, go MEM; BRANCH -> ALUSrc=0, ALUOp=01, PCSrc=1, PCWrite=branch_taken, go FETCH.
REQ-014 MEM: LOAD -> MemRead=1, hold until mem_ready, then go WB; STORE -> MemWrite=1, hold until mem_ready, then go FETCH.
REQ-015 WB: RegWrite=1, MemToReg=1 for LOAD else 0, go FETCH.
REQ-016 Decisions after DECODE SHALL use the latched class only; changes on instruction after DECODE SHALL have no effect.
REQ-017 mem_ready SHALL be ignored outside FETCH and MEM; MemRead and MemWrite SHALL never be high together.
REQ-018 Cycle counts with mem_ready tied 1: R/I 4, LOAD 5, STORE 4, BRANCH 3, ILLEGAL 2.
REQ-019 Unlimited mem_ready wait SHALL hold all outputs stable with no timeout.

Reset
REQ-020 rst_n low SHALL force state=FETCH, latched class=ILLEGAL, and every output 0 immediately, including mid-access.
REQ-021 After rst_n rises, the first clock edge SHALL evaluate FETCH; MemRead SHALL read 1 from release.

Configuration
REQ-022 With CTRL_PERF_CNT_EN defined: outputs cycle_cnt[31:0], counting every clock since reset, and instret_cnt[31:0], incrementing on each exit to FETCH from WB, STORE-MEM, or BRANCH-EXEC (not ILLEGAL); both reset to 0 and wrap 0xFFFFFFFF->0.
REQ-023 Without CTRL_PERF_CNT_EN, those ports and counters SHALL be absent, with function otherwise identical.

Structure
REQ-024 Package rv_ctrl_pkg SHALL hold the state enum, class enum, opcode/funct3 constants, and ALUOp encodings.
REQ-025 Classification SHALL be a combinational sub-module instr_class_decode (instruction in, class out), instantiated once.

Verification
REQ-026 add x3,x1,x2 (0x002081B3), mem_ready=1 -> states 0,1,2,4,0; RegWrite=1 only in WB; ALUOp=10 in EXEC.
REQ-027 lw (0x0000A183), mem_ready delayed 3 cycles in MEM -> MemRead held for 4 MEM cycles, then WB with MemToReg=1; total 8 cycles.
REQ-028 beq (0x00208463), branch_taken=1 then =0 -> PCWrite=1,PCSrc=1 in EXEC; second run PCWrite=0; 3 cycles each.
REQ-029 0xFFFFFFFF -> Illegal pulses 1 cycle in DECODE, returns to FETCH, no RegWrite/MemWrite, instret_cnt unchanged.
REQ-030 rst_n low mid-MEM of sw (0x0020A023) -> MemWrite drops same cycle, state=0; with CTRL_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control unit:
// FSM state encoding, instruction classes, opcode/funct3 values and ALUOp codes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational instruction classifier: looks only at opcode and funct3 and
// sorts the instruction into one of the supported classes or ILLEGAL.
module instr_class_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0]  instruction,
    output instr_class_t instr_class
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = instruction[6:0];
    assign funct3      = instruction[14:12];
    assign unused_bits = ^{instruction[31:15], instruction[11:7]};

    // Map opcode plus permitted funct3 values onto a class; anything else is illegal.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD || funct3 == F3_SLL || funct3 == F3_XOR ||
                    funct3 == F3_SR  || funct3 == F3_OR  || funct3 == F3_AND)
                    instr_class = CLS_R;
            end
            OP_I: begin
                if (funct3 == F3_ADD || funct3 == F3_SLL)
                    instr_class = CLS_I;
            end
            OP_LOAD: begin
                if (funct3 == F3_LW)
                    instr_class = CLS_LOAD;
            end
            OP_STORE: begin
                if (funct3 == F3_SW)
                    instr_class = CLS_STORE;
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE ||
                    funct3 == F3_BLT || funct3 == F3_BGE)
                    instr_class = CLS_BRANCH;
            end
            default: instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
// Control outputs are decoded from the current state, the class latched in
// DECODE and the mem_ready/branch_taken handshakes, and are forced to 0 while
// rst_n is low. Optional performance counters are built when CTRL_PERF_CNT_EN
// is defined.
module multicycle_control
    import rv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IRWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        Illegal,
    output logic [1:0]  ALUOp,
    output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t       state_q;
    instr_class_t cls_q;
    instr_class_t cls_dec;

    instr_class_decode u_decode (
        .instruction (instruction),
        .instr_class (cls_dec)
    );

    assign state = state_q;

    // State sequencing plus the class register that all post-DECODE decisions use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_ILLEGAL;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready)
                        state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    cls_q <= cls_dec;
                    if (cls_dec == CLS_ILLEGAL)
                        state_q <= ST_FETCH;
                    else
                        state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (cls_q)
                        CLS_R, CLS_I:         state_q <= ST_WB;
                        CLS_LOAD, CLS_STORE:  state_q <= ST_MEM;
                        default:              state_q <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (cls_q == CLS_LOAD) begin
                        if (mem_ready)
                            state_q <= ST_WB;
                    end else if (cls_q == CLS_STORE) begin
                        if (mem_ready)
                            state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_WB:   state_q <= ST_FETCH;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Output decode; everything is held at 0 while reset is asserted.
    always_comb begin
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        Illegal  = 1'b0;
        ALUOp    = ALUOP_ADD;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end
                end
                ST_DECODE: begin
                    Illegal = (cls_dec == CLS_ILLEGAL);
                end
                ST_EXEC: begin
                    case (cls_q)
                        CLS_R: begin
                            ALUOp = ALUOP_FUNCT;
                        end
                        CLS_I: begin
                            ALUSrc = 1'b1;
                            ALUOp  = ALUOP_FUNCT;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            ALUSrc = 1'b1;
                        end
                        CLS_BRANCH: begin
                            ALUOp   = ALUOP_BRANCH;
                            PCSrc   = 1'b1;
                            PCWrite = branch_taken;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (cls_q == CLS_LOAD)
                        MemRead = 1'b1;
                    else if (cls_q == CLS_STORE)
                        MemWrite = 1'b1;
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = (cls_q == CLS_LOAD);
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic retire;

    // An instruction retires on the edge that leaves WB, a completed store, or a branch EXEC.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            ST_WB:   retire = 1'b1;
            ST_MEM:  retire = (cls_q == CLS_STORE) && mem_ready;
            ST_EXEC: retire = (cls_q == CLS_BRANCH);
            default: retire = 1'b0;
        endcase
    end

    // Free-running cycle counter and retired-instruction counter, both wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule
